// File: rtl/stack_seq.sv
// stack_seq: reverses framed byte streams through an external LIFO, emitting DEPTH-sized segments in order.
// Optional feature: define STACK_SEQ_ERR_CNT_EN to add a saturating 8-bit err_cnt output.
module stack_seq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic [1:0]       stk_cmd,
   output logic [WIDTH-1:0] stk_data_in,
   input  logic [WIDTH-1:0] stk_data_out,
   input  logic             stk_full,
   input  logic             stk_empty,
   input  logic             stk_error,
   output logic             err,
`ifdef STACK_SEQ_ERR_CNT_EN
   output logic [7:0]       err_cnt,
`endif
   output logic             busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_PUSH = 2'b10;
   localparam logic [1:0] CMD_POP  = 2'b11;

   typedef enum logic [2:0] {INIT, FILL, POP, CAPT, OUT} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          seg_last;
   logic          fill_done;
   logic          prev_op;

   logic hs_in;
   logic op_err;
   logic capt_err;
   logic fault;

   // stk_cmd is registered, so the command issued on an edge is the one the stack sees
   // during the following state; prev_op marks that the stack flags now report a push/pop.
   assign hs_in    = in_valid && in_ready;
   assign op_err   = stk_error && prev_op;
   assign capt_err = (state == CAPT) && stk_empty && (count != '0);
   assign fault    = (state != INIT) && (op_err || capt_err);
   assign busy     = (state != FILL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INIT;
         count       <= '0;
         seg_last    <= 1'b0;
         fill_done   <= 1'b0;
         prev_op     <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
         stk_cmd     <= CMD_NOP;
         stk_data_in <= '0;
         err         <= 1'b0;
      end else begin
         stk_cmd <= CMD_NOP;
         err     <= 1'b0;
         prev_op <= stk_cmd[1];
         if (fault) begin
            state     <= INIT;
            count     <= '0;
            seg_last  <= 1'b0;
            fill_done <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b1;
         end else begin
            case (state)
               INIT: begin
                  stk_cmd   <= CMD_CLR;
                  count     <= '0;
                  seg_last  <= 1'b0;
                  fill_done <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= FILL;
               end
               FILL: begin
                  // fill_done holds FILL one extra cycle so the final push reaches the stack before the pop
                  if (fill_done) begin
                     stk_cmd   <= CMD_POP;
                     count     <= count - CNT_ONE;
                     fill_done <= 1'b0;
                     state     <= POP;
                  end else if (hs_in) begin
                     stk_cmd     <= CMD_PUSH;
                     stk_data_in <= in_data;
                     count       <= count + CNT_ONE;
                     if (in_last || (count == CNT_MAX - CNT_ONE)) begin
                        seg_last  <= in_last;
                        fill_done <= 1'b1;
                        in_ready  <= 1'b0;
                     end else begin
                        in_ready <= !stk_full;
                     end
                  end else begin
                     in_ready <= (count < CNT_MAX) && !stk_full;
                  end
               end
               POP: begin
                  state <= CAPT;
               end
               CAPT: begin
                  out_data  <= stk_data_out;
                  out_valid <= 1'b1;
                  out_last  <= (count == '0) && seg_last;
                  state     <= OUT;
               end
               OUT: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (count != '0) begin
                        stk_cmd <= CMD_POP;
                        count   <= count - CNT_ONE;
                        state   <= POP;
                     end else begin
                        seg_last <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= FILL;
                     end
                  end
               end
               default: state <= INIT;
            endcase
         end
      end
   end

`ifdef STACK_SEQ_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (fault && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: behavioural LIFO beside the DUT, randomized frames checked against a segment-reversal model.
module tb_stack_seq;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam logic [8:0] DEPTH9 = 9'(DEPTH);
   localparam logic [1:0] C_NOP  = 2'b00;
   localparam logic [1:0] C_CLR  = 2'b01;
   localparam logic [1:0] C_PUSH = 2'b10;
   localparam logic [1:0] C_POP  = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_last;
   logic             out_ready = 1'b0;
   logic [1:0]       stk_cmd;
   logic [WIDTH-1:0] stk_data_in;
   logic [WIDTH-1:0] stk_data_out = '0;
   logic             stk_full;
   logic             stk_empty;
   logic             stk_error = 1'b0;
   logic             err;
   logic             busy;
`ifdef STACK_SEQ_ERR_CNT_EN
   logic [7:0]       err_cnt;
`endif

   stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .stk_cmd(stk_cmd), .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
      .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error),
      .err(err),
`ifdef STACK_SEQ_ERR_CNT_EN
      .err_cnt(err_cnt),
`endif
      .busy(busy));

   always #5 clk = ~clk;

   // Behavioural stack; pops can be made to fail or to report a bogus empty flag on request.
   logic [WIDTH-1:0] mem [0:511];
   logic [8:0] sp = '0;
   int inj_pop_req = 0, inj_pop_done = 0, emp_req = 0, emp_done = 0;
   logic fake_empty = 1'b0;
   assign stk_full  = (sp >= DEPTH9);
   assign stk_empty = (sp == '0) || fake_empty;

   always @(posedge clk) begin
      stk_error  <= 1'b0;
      fake_empty <= 1'b0;
      case (stk_cmd)
         C_CLR: sp <= '0;
         C_PUSH: begin
            if (sp >= DEPTH9) stk_error <= 1'b1;
            else begin mem[sp] <= stk_data_in; sp <= sp + 9'd1; end
         end
         C_POP: begin
            if (inj_pop_req != inj_pop_done) begin
               stk_error <= 1'b1; inj_pop_done <= inj_pop_done + 1;
            end else if (sp == '0) stk_error <= 1'b1;
            else begin
               stk_data_out <= mem[sp - 9'd1]; sp <= sp - 9'd1;
               if (emp_req != emp_done) begin fake_empty <= 1'b1; emp_done <= emp_done + 1; end
            end
         end
         default: ;
      endcase
   end

   logic [8:0] got_q[$];
   logic [1:0] cmd_q[$];
   int viol = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) got_q.push_back({out_last, out_data});
         if (stk_cmd != C_NOP) cmd_q.push_back(stk_cmd);
         if ((stk_cmd == C_POP && out_valid) || (in_ready && (out_valid || busy))) viol <= viol + 1;
      end
   end

   int checks = 0, errors = 0;
   logic [7:0] frm[$];
   logic [8:0] exp_q[$];

   task automatic tick(); @(posedge clk); #1; endtask

   // Reference: split the frame into DEPTH-sized chunks in arrival order, reverse each chunk,
   // and flag the last emitted byte of the final chunk.
   function automatic void build_exp();
      int n = frm.size();
      exp_q.delete();
      for (int s = 0; s < n; s += DEPTH) begin
         int e = (s + DEPTH < n) ? s + DEPTH : n;
         for (int j = e - 1; j >= s; j--) exp_q.push_back({(j == s) && (e == n), frm[j]});
      end
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic drive_frame(input int gap_pct);
      int to;
      for (int i = 0; i < frm.size(); i++) begin
         while ($urandom_range(99) < gap_pct) begin in_valid = 1'b0; tick(); end
         in_valid = 1'b1; in_data = frm[i]; in_last = (i == frm.size() - 1);
         to = 0;
         while (!in_ready && to < 500) begin tick(); to++; end
         checks++;
         if (!in_ready) begin
            errors++;
            $display("FAIL in_accept byte %0d: in_ready=%b required 1 within 500 cycles", i, in_ready);
            break;
         end
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain(input int n, input int rdy_pct, input int start);
      int cyc = 0;
      while (got_q.size() < start + n && cyc < 200 + 40 * n) begin
         out_ready = ($urandom_range(99) < rdy_pct); tick(); cyc++;
      end
      out_ready = 1'b0;
   endtask

   task automatic run_frame(input int gap_pct, input int rdy_pct);
      int start = got_q.size();
      build_exp();
      fork
         drive_frame(gap_pct);
         drain(exp_q.size(), rdy_pct, start);
      join
   endtask

   task automatic wait_err();
      int cyc = 0;
      while (!err && cyc < 60) begin tick(); cyc++; end
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: err=%b required 1", err); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h required 00", out_data); end
      checks++; if (stk_cmd !== C_NOP) begin errors++; $display("FAIL rst_stk_cmd: got %b required 00", stk_cmd); end
      checks++; if (stk_data_in !== 8'h00) begin errors++; $display("FAIL rst_stk_data_in: got %h required 00", stk_data_in); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", busy); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (stk_cmd !== C_CLR) begin errors++; $display("FAIL rst_first_clear: stk_cmd=%b required 01", stk_cmd); end
      tick();
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_to_fill: busy=%b in_ready=%b required 0 1", busy, in_ready); end
   endtask

   task automatic test_basic();
      logic [1:0] exp_cmd [7] = '{C_CLR, C_PUSH, C_PUSH, C_PUSH, C_POP, C_POP, C_POP};
      int cstart, gstart;
      apply_reset();
      cstart = cmd_q.size(); gstart = got_q.size();
      frm.delete(); frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
      run_frame(0, 100);
      tick(); tick();
      checks++;
      if (got_q.size() - gstart != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d beats required %0d", got_q.size() - gstart, exp_q.size()); end
      for (int k = 0; k < exp_q.size() && gstart + k < got_q.size(); k++) begin
         checks++;
         if (got_q[gstart + k] !== exp_q[k]) begin errors++; $display("FAIL basic_beat %0d: got last/data %h required %h", k, got_q[gstart + k], exp_q[k]); end
      end
      checks++;
      if (cmd_q.size() - cstart != 7) begin errors++; $display("FAIL basic_cmd_count: got %0d commands required 7", cmd_q.size() - cstart); end
      for (int k = 0; k < 7 && cstart + k < cmd_q.size(); k++) begin
         checks++;
         if (cmd_q[cstart + k] !== exp_cmd[k]) begin errors++; $display("FAIL basic_cmd %0d: got %b required %b", k, cmd_q[cstart + k], exp_cmd[k]); end
      end
   endtask

   task automatic test_long_frame();
      int gstart = got_q.size();
      int v0 = viol;
      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(8'(i + 1));
      run_frame(0, 100);
      checks++;
      if (got_q.size() - gstart != exp_q.size()) begin errors++; $display("FAIL long_count: got %0d beats required %0d", got_q.size() - gstart, exp_q.size()); end
      for (int k = 0; k < exp_q.size() && gstart + k < got_q.size(); k++) begin
         checks++;
         if (got_q[gstart + k] !== exp_q[k]) begin errors++; $display("FAIL long_beat %0d: got last/data %h required %h", k, got_q[gstart + k], exp_q[k]); end
      end
      checks++;
      if (viol != v0) begin errors++; $display("FAIL long_protocol: %0d violations required 0", viol - v0); end
   endtask

   task automatic test_backpressure();
      int cstart = cmd_q.size();
      int gstart = got_q.size();
      int pops, cyc;
      frm.delete();
      for (int i = 0; i < 5; i++) frm.push_back(8'(i + 1));
      build_exp();
      out_ready = 1'b0;
      drive_frame(0);
      cyc = 0;
      while (!out_valid && cyc < 60) begin tick(); cyc++; end
      for (int h = 0; h < 5; h++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h05) begin errors++; $display("FAIL bp_hold cycle %0d: valid=%b data=%h required 1 05", h, out_valid, out_data); end
         tick();
      end
      pops = 0;
      for (int k = cstart; k < cmd_q.size(); k++) if (cmd_q[k] == C_POP) pops++;
      checks++;
      if (pops != 1) begin errors++; $display("FAIL bp_pops_held: got %0d pops required 1", pops); end
      drain(5, 100, gstart);
      tick(); tick();
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (gstart + k >= got_q.size() || got_q[gstart + k] !== exp_q[k]) begin errors++; $display("FAIL bp_beat %0d: required last/data %h", k, exp_q[k]); end
      end
      pops = 0;
      for (int k = cstart; k < cmd_q.size(); k++) if (cmd_q[k] == C_POP) pops++;
      checks++;
      if (pops != 5) begin errors++; $display("FAIL bp_pops_total: got %0d pops required 5", pops); end
   endtask

   task automatic test_random();
      int v0 = viol;
      for (int f = 0; f < 8; f++) begin
         int gstart = got_q.size();
         int n = $urandom_range(2 * DEPTH + 3, 1);
         frm.delete();
         for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
         run_frame(30, 60);
         checks++;
         if (got_q.size() - gstart != exp_q.size()) begin errors++; $display("FAIL rand_count frame %0d: got %0d beats required %0d", f, got_q.size() - gstart, exp_q.size()); end
         for (int k = 0; k < exp_q.size() && gstart + k < got_q.size(); k++) begin
            checks++;
            if (got_q[gstart + k] !== exp_q[k]) begin errors++; $display("FAIL rand_beat frame %0d beat %0d: got %h required %h", f, k, got_q[gstart + k], exp_q[k]); end
         end
      end
      checks++;
      if (viol != v0) begin errors++; $display("FAIL rand_protocol: %0d violations required 0", viol - v0); end
   endtask

   task automatic test_error();
      int gstart = got_q.size();
      inj_pop_req++;
      frm.delete(); frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
      out_ready = 1'b1;
      drive_frame(0);
      wait_err();
      checks++; if (got_q.size() != gstart) begin errors++; $display("FAIL err_discard: got %0d beats required 0", got_q.size() - gstart); end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_state: out_valid=%b busy=%b required 0 1", out_valid, busy); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width: err=%b required 0", err); end
      checks++; if (stk_cmd !== C_CLR) begin errors++; $display("FAIL err_clear: stk_cmd=%b required 01", stk_cmd); end
      tick();
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_refill: in_ready=%b busy=%b required 1 0", in_ready, busy); end
      gstart = got_q.size();
      frm.delete(); frm.push_back(8'hA1); frm.push_back(8'hA2);
      run_frame(0, 100);
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (gstart + k >= got_q.size() || got_q[gstart + k] !== exp_q[k]) begin errors++; $display("FAIL err_recover beat %0d: required %h", k, exp_q[k]); end
      end
      gstart = got_q.size();
      emp_req++;
      frm.delete(); frm.push_back(8'h44); frm.push_back(8'h55); frm.push_back(8'h66);
      out_ready = 1'b1;
      drive_frame(0);
      wait_err();
      checks++; if (got_q.size() != gstart) begin errors++; $display("FAIL empty_discard: got %0d beats required 0", got_q.size() - gstart); end
      tick(); tick();
      out_ready = 1'b0;
   endtask

`ifdef STACK_SEQ_ERR_CNT_EN
   task automatic test_err_cnt();
      apply_reset();
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_reset: got %0d required 0", err_cnt); end
      out_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         inj_pop_req++;
         frm.delete(); frm.push_back(8'(k));
         drive_frame(0);
         wait_err();
         tick();
         if (k == 1) begin
            checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL errcnt_two: got %0d required 2", err_cnt); end
         end
      end
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL errcnt_sat: got %0d required 255", err_cnt); end
      out_ready = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_drain();
      int gstart, cyc;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(8'hC1 + 8'(i));
      out_ready = 1'b0;
      drive_frame(0);
      cyc = 0;
      while (!out_valid && cyc < 60) begin tick(); cyc++; end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, err} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: in_ready/out_valid/out_last/err=%b required 0000", {in_ready, out_valid, out_last, err}); end
      checks++;
      if (out_data !== 8'h00 || stk_data_in !== 8'h00 || stk_cmd !== C_NOP) begin errors++; $display("FAIL mid_rst_data: out_data=%h stk_data_in=%h stk_cmd=%b required 00 00 00", out_data, stk_data_in, stk_cmd); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (stk_cmd !== C_CLR) begin errors++; $display("FAIL mid_rst_clear: stk_cmd=%b required 01", stk_cmd); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_fill: busy=%b required 0", busy); end
      gstart = got_q.size();
      frm.delete();
      for (int i = 0; i < DEPTH + 2; i++) frm.push_back(8'($urandom));
      run_frame(10, 80);
      checks++;
      if (got_q.size() - gstart != exp_q.size()) begin errors++; $display("FAIL mid_rst_count: got %0d beats required %0d", got_q.size() - gstart, exp_q.size()); end
      for (int k = 0; k < exp_q.size() && gstart + k < got_q.size(); k++) begin
         checks++;
         if (got_q[gstart + k] !== exp_q[k]) begin errors++; $display("FAIL mid_rst_beat %0d: got %h required %h", k, got_q[gstart + k], exp_q[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_long_frame();
      test_backpressure();
      test_random();
      test_error();
`ifdef STACK_SEQ_ERR_CNT_EN
      test_err_cnt();
`endif
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
